// File: rtl/transmit_dac_pkg.sv
// Shared definitions for the serial DAC transmitter: frame width,
// FSM state encodings and the DAC power-down mode codes.
package dac_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned PD_W    = 2;

  localparam logic [PD_W-1:0] PD_NORMAL = 2'b00;
  localparam logic [PD_W-1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/transmit_dac_if.sv
// Host-side request/status and DAC serial pins of transmit_dac.
//   master: drives tx_start, din, pd_mode; observes status and DAC pins
//   slave : the transmitter itself
interface transmit_dac_if #(
  parameter int unsigned DATA_W = 12
);
  import dac_pkg::*;

  logic              tx_start;
  logic [DATA_W-1:0] din;
  logic [PD_W-1:0]   pd_mode;
  logic              tx_busy;
  logic              tx_done_tick;
  logic              cs;
  logic              sclk_dac;
  logic              sdata_dac;

  modport master (
    output tx_start, din, pd_mode,
    input  tx_busy, tx_done_tick, cs, sclk_dac, sdata_dac
  );

  modport slave (
    input  tx_start, din, pd_mode,
    output tx_busy, tx_done_tick, cs, sclk_dac, sdata_dac
  );

endinterface

// File: rtl/transmit_dac_half_period_counter.sv
// Free-running DIV-cycle divider for sclk_dac half periods.
//   clk, rst : clock, async active-low reset
//   en       : count while high, held at 0 while low
//   cnt      : current position inside the half period (0..DIV-1)
//   tick_c   : combinational, high on the last cycle of a half period
module half_period_counter #(
  parameter int unsigned DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [$clog2(DIV)-1:0] cnt,
  output logic                   tick_c
);

  localparam int unsigned CNT_W = $clog2(DIV);

  assign tick_c = en && (cnt == CNT_W'(DIV - 1));

  // Wraps DIV-1 -> 0; cleared whenever disabled so every frame starts aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= '0;
    else if (!en)     cnt <= '0;
    else if (tick_c)  cnt <= '0;
    else              cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/transmit_dac.sv
// Serial DAC transmitter: sends {2'b00, pd_mode, din} MSB first on
// cs/sclk_dac/sdata_dac, sclk_dac half period = DIV clk cycles.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of transmit_dac_if (request, status, DAC pins)
module transmit_dac
  import dac_pkg::*;
#(
  parameter int unsigned DIV    = 4,
  parameter int unsigned DATA_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  transmit_dac_if.slave        bus
);

  localparam int unsigned CNT_W = $clog2(DIV);

  state_e             state, state_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [FRAME_W-2:0] shreg, shreg_n;   // bits still to send after sdata
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               cs_q, cs_n;
  logic               sclk_q, sclk_n;
  logic               sdata_q, sdata_n;

  logic [CNT_W-1:0]   cnt;
  logic               tick_c;
  logic [FRAME_W-1:0] frame_c;

  assign frame_c = FRAME_W'({2'b00, bus.pd_mode, bus.din});

  half_period_counter #(.DIV(DIV)) u_hp_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (state != IDLE),
    .cnt    (cnt),
    .tick_c (tick_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      sdata_q <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      cs_q    <= cs_n;
      sclk_q  <= sclk_n;
      sdata_q <= sdata_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    busy_n    = busy_q;
    done_n    = 1'b0;
    cs_n      = cs_q;
    sclk_n    = sclk_q;
    sdata_n   = sdata_q;

    unique case (state)
      IDLE: begin
        if (bus.tx_start) begin
          state_n   = SETUP;
          bit_cnt_n = BIT_W'(FRAME_W - 1);
          shreg_n   = frame_c[FRAME_W-2:0];
          busy_n    = 1'b1;
          cs_n      = 1'b0;
          sclk_n    = 1'b1;
          sdata_n   = frame_c[FRAME_W-1];
        end
      end

      SETUP: begin
        if (tick_c) begin
          state_n = SHIFT;
          sclk_n  = 1'b0;
        end
      end

      // sclk_q low = first half of a bit (DAC sampled on its falling edge).
      // Data only moves on the rising edge; bit 0 keeps its value through
      // its closing high half so every bit gets a full sclk period.
      SHIFT: begin
        if (tick_c) begin
          if (!sclk_q) begin
            sclk_n = 1'b1;
            if (bit_cnt != '0) begin
              sdata_n = shreg[FRAME_W-2];
              shreg_n = {shreg[FRAME_W-3:0], 1'b0};
            end
          end else if (bit_cnt == '0) begin
            state_n = HOLD;
            cs_n    = 1'b1;
            sdata_n = 1'b0;
          end else begin
            sclk_n    = 1'b0;
            bit_cnt_n = bit_cnt - BIT_W'(1);
          end
        end
      end

      // Done pulse is registered one cycle early so it lands on the last cycle.
      HOLD: begin
        if (cnt == CNT_W'(DIV - 2)) done_n = 1'b1;
        if (tick_c) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          shreg_n = '0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;
  assign bus.cs           = cs_q;
  assign bus.sclk_dac     = sclk_q;
  assign bus.sdata_dac    = sdata_q;

endmodule

// File: tb/tb_transmit_dac.sv
// Directed bench for transmit_dac at DIV=4: frame content, frame timing,
// ignored requests while busy, mid-frame reset and back-to-back frames.
module tb_transmit_dac;
  import dac_pkg::*;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  transmit_dac_if #(.DATA_W(12)) dac_bus ();

  transmit_dac #(.DIV(DIV), .DATA_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dac_bus)
  );

  int checks   = 0;
  int failures = 0;

  // Passive DAC-side monitor: cumulative counters sampled on the clk falling edge.
  logic        prev_sclk = 1'b1;
  logic [15:0] cap_word  = '0;
  int          fall_cnt  = 0;
  int          busy_cyc  = 0;
  int          cslow_cyc = 0;
  int          tick_cnt  = 0;

  always @(negedge clk) begin
    if (prev_sclk === 1'b1 && dac_bus.sclk_dac === 1'b0 && dac_bus.cs === 1'b0) begin
      cap_word <= {cap_word[14:0], dac_bus.sdata_dac};
      fall_cnt <= fall_cnt + 1;
    end
    if (dac_bus.tx_busy === 1'b1)      busy_cyc  <= busy_cyc + 1;
    if (dac_bus.cs === 1'b0)           cslow_cyc <= cslow_cyc + 1;
    if (dac_bus.tx_done_tick === 1'b1) tick_cnt  <= tick_cnt + 1;
    prev_sclk <= dac_bus.sclk_dac;
  end

  // Pulse tx_start for one cycle and wait (bounded) for tx_busy to drop.
  task automatic run_frame(input logic [11:0] d, input logic [1:0] pd, output bit ok);
    @(negedge clk);
    dac_bus.din      = d;
    dac_bus.pd_mode  = pd;
    dac_bus.tx_start = 1'b1;
    @(negedge clk);
    dac_bus.tx_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dac_bus.tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1;
    dac_bus.tx_start = 1'b0;
    dac_bus.din      = '0;
    dac_bus.pd_mode  = PD_NORMAL;
    #3 rst = 1'b0;
    #1;
    obs = {dac_bus.cs, dac_bus.sclk_dac, dac_bus.sdata_dac, dac_bus.tx_busy, dac_bus.tx_done_tick};
    checks++;
    if (obs !== 5'b11000) begin
      failures++;
      $display("FAIL reset_outputs {cs,sclk,sdata,busy,done} got=%b exp=%b", obs, 5'b11000);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      obs = {dac_bus.cs, dac_bus.sclk_dac, dac_bus.sdata_dac, dac_bus.tx_busy, dac_bus.tx_done_tick};
      checks++;
      if (obs !== 5'b11000) begin
        failures++;
        $display("FAIL idle_after_reset cycle=%0d got=%b exp=%b", i, obs, 5'b11000);
      end
    end
  endtask

  task automatic test_basic_frame();
    int f0, b0, c0, t0;
    bit ok;
    f0 = fall_cnt; b0 = busy_cyc; c0 = cslow_cyc; t0 = tick_cnt;
    run_frame(12'hA5C, PD_NORMAL, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout busy never dropped"); end
    checks++;
    if (cap_word !== 16'h0A5C) begin failures++; $display("FAIL basic_word got=%h exp=%h", cap_word, 16'h0A5C); end
    checks++;
    if (fall_cnt - f0 != 16) begin failures++; $display("FAIL basic_falls got=%0d exp=16", fall_cnt - f0); end
    checks++;
    if (busy_cyc - b0 != 34 * DIV) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cyc - b0, 34 * DIV); end
    checks++;
    if (cslow_cyc - c0 != 33 * DIV) begin failures++; $display("FAIL basic_cs_low got=%0d exp=%0d", cslow_cyc - c0, 33 * DIV); end
    checks++;
    if (tick_cnt - t0 != 1) begin failures++; $display("FAIL basic_ticks got=%0d exp=1", tick_cnt - t0); end
  endtask

  task automatic test_hiz_frame();
    int f0, t0;
    bit ok;
    f0 = fall_cnt; t0 = tick_cnt;
    run_frame(12'hFFF, PD_HIZ, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hiz_timeout busy never dropped"); end
    checks++;
    if (cap_word !== 16'h3FFF) begin failures++; $display("FAIL hiz_word got=%h exp=%h", cap_word, 16'h3FFF); end
    checks++;
    if (fall_cnt - f0 != 16) begin failures++; $display("FAIL hiz_falls got=%0d exp=16", fall_cnt - f0); end
    checks++;
    if (tick_cnt - t0 != 1) begin failures++; $display("FAIL hiz_ticks got=%0d exp=1", tick_cnt - t0); end
  endtask

  task automatic test_mid_frame();
    int t0, busy_after;
    bit ok;
    t0 = tick_cnt;
    @(negedge clk);
    dac_bus.din      = 12'hA5C;
    dac_bus.pd_mode  = PD_NORMAL;
    dac_bus.tx_start = 1'b1;
    @(negedge clk);
    dac_bus.tx_start = 1'b0;
    repeat (40) @(negedge clk);
    dac_bus.din      = 12'h000;
    dac_bus.pd_mode  = PD_HIZ;
    dac_bus.tx_start = 1'b1;
    @(negedge clk);
    dac_bus.tx_start = 1'b0;
    repeat (30) @(negedge clk);
    dac_bus.tx_start = 1'b1;
    @(negedge clk);
    dac_bus.tx_start = 1'b0;
    // Also request on the done-tick cycle itself.
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dac_bus.tx_done_tick === 1'b1) begin
        dac_bus.tx_start = 1'b1;
        @(negedge clk);
        dac_bus.tx_start = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    busy_after = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dac_bus.tx_busy !== 1'b0) busy_after++;
    end
    #1;
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_timeout no done tick seen"); end
    checks++;
    if (cap_word !== 16'h0A5C) begin failures++; $display("FAIL mid_word got=%h exp=%h", cap_word, 16'h0A5C); end
    checks++;
    if (tick_cnt - t0 != 1) begin failures++; $display("FAIL mid_ticks got=%0d exp=1", tick_cnt - t0); end
    checks++;
    if (busy_after != 0) begin failures++; $display("FAIL mid_queued busy_cycles_after=%0d exp=0", busy_after); end
  endtask

  task automatic test_reset_mid();
    int f0, t0, b0, busy_rst;
    bit ok, reached;
    logic [4:0] obs;
    f0 = fall_cnt; t0 = tick_cnt;
    @(negedge clk);
    dac_bus.din      = 12'hA5C;
    dac_bus.pd_mode  = PD_NORMAL;
    dac_bus.tx_start = 1'b1;
    @(negedge clk);
    dac_bus.tx_start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (fall_cnt - f0 >= 8) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL rstmid_timeout bit 8 never reached falls=%0d", fall_cnt - f0); end
    #2 rst = 1'b0;
    #1;
    obs = {dac_bus.cs, dac_bus.sclk_dac, dac_bus.sdata_dac, dac_bus.tx_busy, dac_bus.tx_done_tick};
    checks++;
    if (obs !== 5'b11000) begin failures++; $display("FAIL rstmid_outputs got=%b exp=%b", obs, 5'b11000); end
    busy_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (dac_bus.tx_busy !== 1'b0) busy_rst++;
    end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (tick_cnt - t0 != 0 || busy_rst != 0) begin
      failures++;
      $display("FAIL rstmid_abort ticks=%0d busy_in_reset=%0d exp=0,0", tick_cnt - t0, busy_rst);
    end
    f0 = fall_cnt; t0 = tick_cnt; b0 = busy_cyc;
    run_frame(12'h123, PD_NORMAL, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_next_timeout busy never dropped"); end
    checks++;
    if (cap_word !== 16'h0123) begin failures++; $display("FAIL rstmid_next_word got=%h exp=%h", cap_word, 16'h0123); end
    checks++;
    if (fall_cnt - f0 != 16) begin failures++; $display("FAIL rstmid_next_falls got=%0d exp=16", fall_cnt - f0); end
    checks++;
    if (tick_cnt - t0 != 1) begin failures++; $display("FAIL rstmid_next_ticks got=%0d exp=1", tick_cnt - t0); end
    checks++;
    if (busy_cyc - b0 != 34 * DIV) begin failures++; $display("FAIL rstmid_next_busy got=%0d exp=%0d", busy_cyc - b0, 34 * DIV); end
  endtask

  task automatic test_back_to_back();
    int ticks, ngap, gap_len, t_after;
    int gaps[4];
    bit seen_low, in_gap;
    ticks = 0; ngap = 0; gap_len = 0; seen_low = 1'b0; in_gap = 1'b0;
    gaps = '{default: 0};
    @(negedge clk);
    dac_bus.din      = 12'hA5C;
    dac_bus.pd_mode  = PD_NORMAL;
    dac_bus.tx_start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dac_bus.cs === 1'b0) begin
        if (in_gap) begin
          if (ngap < 4) gaps[ngap] = gap_len;
          ngap++;
          in_gap = 1'b0;
        end
        seen_low = 1'b1;
      end else if (seen_low) begin
        if (!in_gap) begin
          in_gap  = 1'b1;
          gap_len = 0;
        end
        gap_len++;
      end
      if (dac_bus.tx_done_tick === 1'b1) begin
        ticks++;
        if (ticks == 3) break;
      end
    end
    dac_bus.tx_start = 1'b0;
    t_after = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dac_bus.tx_busy !== 1'b0) t_after++;
    end
    checks++;
    if (ticks != 3) begin failures++; $display("FAIL b2b_ticks got=%0d exp=3", ticks); end
    checks++;
    if (ngap != 2) begin failures++; $display("FAIL b2b_gap_count got=%0d exp=2", ngap); end
    checks++;
    if (gaps[0] != DIV + 1) begin failures++; $display("FAIL b2b_gap0 got=%0d exp=%0d", gaps[0], DIV + 1); end
    checks++;
    if (gaps[1] != DIV + 1) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=%0d", gaps[1], DIV + 1); end
    checks++;
    if (t_after != 0) begin failures++; $display("FAIL b2b_extra_frame busy_cycles_after=%0d exp=0", t_after); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hiz_frame();
    test_mid_frame();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
